// File: rtl/banner_scroller_if.sv
// Banner scroller bus: run control, banner ROM port and visible-row stream.
// The master side is the scroller; the slave side is ROM plus downstream consumer.
interface banner_scroller_if #(
    parameter int WINDOW = 32,
    parameter int SRC_W  = 70
);
    logic              run;
    logic [4:0]        rom_addr;
    logic [SRC_W-1:0]  rom_data;
    logic [WINDOW-1:0] row_data;
    logic [4:0]        row_idx;
    logic              row_valid;
    logic              row_ready;
    logic              frame_done;
    logic [6:0]        offset;

    modport master (
        input  run, rom_data, row_ready,
        output rom_addr, row_data, row_idx, row_valid, frame_done, offset
    );

    modport slave (
        output run, rom_data, row_ready,
        input  rom_addr, row_data, row_idx, row_valid, frame_done, offset
    );
endinterface

// File: rtl/banner_scroller.sv
// Fetches banner rows from a 1-cycle-latency ROM and streams a WINDOW-wide,
// horizontally scrolling slice of each row; offset advances every SCROLL_DIV frames.
//
// state | meaning
// IDLE  | waiting for run; row counter held at 0
// ADDR  | rom_addr presented, ROM samples it at the next edge
// WAIT  | rom_data valid; windowed slice captured into row_data
// EMIT  | row_valid high until the consumer accepts
module banner_scroller #(
    parameter int WINDOW     = 32,
    parameter int ROWS       = 15,
    parameter int SRC_W      = 70,
    parameter int SCROLL_DIV = 4
) (
    input logic               clk,
    input logic               rst,
    banner_scroller_if.master bus
);
    localparam int IW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, EMIT} state_t;

    state_t            state_q, state_d;
    logic [4:0]        row_cnt_q, row_cnt_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [6:0]        offset_q, offset_d;
    logic [WINDOW-1:0] row_data_q, row_data_d;
    logic [4:0]        row_idx_q, row_idx_d;
    logic              frame_done_q, frame_done_d;
    logic [WINDOW-1:0] window;

    // Column c of the window is banner column (offset + c) wrapped once; WINDOW <= SRC_W.
    always_comb begin
        window = '0;
        for (int c = 0; c < WINDOW; c++) begin
            int col;
            col = int'(offset_q) + c;
            if (col >= SRC_W) col = col - SRC_W;
            window[WW'(WINDOW-1-c)] = bus.rom_data[IW'(SRC_W-1-col)];
        end
    end

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        offset_d     = offset_q;
        row_data_d   = row_data_q;
        row_idx_d    = row_idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                row_cnt_d = '0;
                if (bus.run) state_d = ADDR;
            end
            ADDR: state_d = WAIT;
            WAIT: begin
                row_data_d = window;
                row_idx_d  = row_cnt_q;
                state_d    = EMIT;
            end
            EMIT: begin
                if (bus.row_ready) begin
                    if (row_cnt_q == 5'(ROWS-1)) begin
                        frame_done_d = 1'b1;
                        row_cnt_d    = '0;
                        state_d      = bus.run ? ADDR : IDLE;
                        // Offset only moves between frames, so a frame never mixes offsets.
                        if (frame_cnt_q == 8'(SCROLL_DIV-1)) begin
                            frame_cnt_d = '0;
                            offset_d    = (offset_q == 7'(SRC_W-1)) ? 7'd0 : offset_q + 7'd1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 5'd1;
                        state_d   = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            offset_q     <= '0;
            row_data_q   <= '0;
            row_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            offset_q     <= offset_d;
            row_data_q   <= row_data_d;
            row_idx_q    <= row_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rom_addr   = row_cnt_q;
    assign bus.row_data   = row_data_q;
    assign bus.row_idx    = row_idx_q;
    assign bus.row_valid  = (state_q == EMIT);
    assign bus.frame_done = frame_done_q;
    assign bus.offset     = offset_q;
endmodule

// File: tb/tb_banner_scroller.sv
// Self-checking bench for banner_scroller: two instances (SCROLL_DIV 4 and 1)
// checked against a column-formula window model and frame/offset bookkeeping.
module tb_banner_scroller;
    localparam int WINDOW = 32;
    localparam int ROWS   = 15;
    localparam int SRC_W  = 70;
    localparam int DIV_A  = 4;
    localparam int WW     = $clog2(WINDOW);
    localparam int IW     = $clog2(SRC_W);

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    banner_scroller_if #(.WINDOW(WINDOW), .SRC_W(SRC_W)) bus_a();
    banner_scroller_if #(.WINDOW(WINDOW), .SRC_W(SRC_W)) bus_b();

    banner_scroller #(.WINDOW(WINDOW), .ROWS(ROWS), .SRC_W(SRC_W), .SCROLL_DIV(DIV_A))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    banner_scroller #(.WINDOW(WINDOW), .ROWS(ROWS), .SRC_W(SRC_W), .SCROLL_DIV(1))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

    logic [SRC_W-1:0] rom_mem [32];
    always @(posedge clk) begin
        bus_a.rom_data <= rom_mem[bus_a.rom_addr];
        bus_b.rom_data <= rom_mem[bus_b.rom_addr];
    end

    int cyc = 0;
    int fd_a = 0, fd_b = 0, last_fd_a = -1;
    int checks = 0, passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.frame_done === 1'b1) begin
            fd_a++;
            last_fd_a = cyc;
        end
        if (bus_b.frame_done === 1'b1) fd_b++;
    end

    function automatic logic [SRC_W-1:0] rom_row(input int r);
        return rom_mem[5'(r)];
    endfunction

    // Reference window straight from the column definition, with modulo wrap.
    function automatic logic [WINDOW-1:0] exp_window(input logic [SRC_W-1:0] row, input int off);
        logic [WINDOW-1:0] w;
        w = '0;
        for (int c = 0; c < WINDOW; c++)
            w[WW'(WINDOW-1-c)] = row[IW'(SRC_W-1-((off+c) % SRC_W))];
        return w;
    endfunction

    task automatic load_spec_rom();
        logic [SRC_W-1:0] v;
        for (int r = 0; r < 32; r++) begin
            v = '0;
            if (r < ROWS) begin
                v[SRC_W-1] = 1'b1;
                v[4:0]     = 5'(r);
            end
            rom_mem[r] = v;
        end
    endtask

    task automatic load_random_rom();
        logic [95:0] t;
        for (int r = 0; r < 32; r++) begin
            t = {$urandom(), $urandom(), $urandom()};
            rom_mem[r] = t[SRC_W-1:0];
        end
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.run = 1'b0;
        bus_a.row_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic get_row(input bit sel, input int budget, output bit ok, output int waits,
                           output logic [WINDOW-1:0] data, output logic [4:0] idx, output logic [6:0] off);
        logic v;
        ok = 1'b0; waits = 0; data = '0; idx = '0; off = '0;
        while (!ok && waits < budget) begin
            @(negedge clk);
            waits++;
            v = sel ? bus_b.row_valid : bus_a.row_valid;
            if (v === 1'b1) begin
                ok   = 1'b1;
                data = sel ? bus_b.row_data : bus_a.row_data;
                idx  = sel ? bus_b.row_idx : bus_a.row_idx;
                off  = sel ? bus_b.offset : bus_a.offset;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.run = 1'b1;
        bus_a.row_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.row_valid !== 1'b0) $display("FAIL reset_row_valid: got %b expected 0", bus_a.row_valid); else passes++;
        checks++; if (bus_a.row_data !== '0) $display("FAIL reset_row_data: got %h expected 0", bus_a.row_data); else passes++;
        checks++; if (bus_a.row_idx !== 5'd0) $display("FAIL reset_row_idx: got %0d expected 0", bus_a.row_idx); else passes++;
        checks++; if (bus_a.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", bus_a.frame_done); else passes++;
        checks++; if (bus_a.rom_addr !== 5'd0) $display("FAIL reset_rom_addr: got %0d expected 0", bus_a.rom_addr); else passes++;
        checks++; if (bus_a.offset !== 7'd0) $display("FAIL reset_offset: got %0d expected 0", bus_a.offset); else passes++;
    endtask

    task automatic test_frame();
        bit ok; int waits; logic [WINDOW-1:0] d; logic [4:0] idx; logic [6:0] off;
        int fd0, c14;
        load_spec_rom();
        reset_a();
        bus_a.row_ready = 1'b1;
        bus_a.run = 1'b1;
        fd0 = fd_a; c14 = 0;
        for (int r = 0; r <= ROWS; r++) begin
            get_row(1'b0, 20, ok, waits, d, idx, off);
            checks++; if (!ok) $display("FAIL frame_timeout row %0d: got no row_valid, expected one within 20 cycles", r); else passes++;
            checks++; if (waits !== 3) $display("FAIL frame_spacing row %0d: got %0d cycles expected 3", r, waits); else passes++;
            checks++; if (idx !== 5'(r % ROWS)) $display("FAIL frame_row_idx: got %0d expected %0d", idx, r % ROWS); else passes++;
            checks++; if (d !== exp_window(rom_row(r % ROWS), 0)) $display("FAIL frame_row_data row %0d: got %h expected %h", r, d, exp_window(rom_row(r % ROWS), 0)); else passes++;
            checks++; if (d[WINDOW-1] !== 1'b1) $display("FAIL frame_bit31 row %0d: got %b expected 1", r, d[WINDOW-1]); else passes++;
            if (r == ROWS-1) c14 = cyc;
        end
        checks++; if (fd_a - fd0 !== 1) $display("FAIL frame_done_count: got %0d expected 1", fd_a - fd0); else passes++;
        checks++; if (last_fd_a !== c14 + 1) $display("FAIL frame_done_cycle: got %0d expected %0d", last_fd_a, c14 + 1); else passes++;
    endtask

    task automatic test_backpressure();
        bit ok; int waits; logic [WINDOW-1:0] d, d5; logic [4:0] idx; logic [6:0] off;
        for (int r = 1; r <= 5; r++) begin
            get_row(1'b0, 20, ok, waits, d, idx, off);
            checks++; if (!ok || idx !== 5'(r)) $display("FAIL bp_lead_row: got ok=%0d idx=%0d expected ok=1 idx=%0d", ok, idx, r); else passes++;
        end
        bus_a.row_ready = 1'b0;
        d5 = d;
        checks++; if (d5 !== exp_window(rom_row(5), 0)) $display("FAIL bp_row5_data: got %h expected %h", d5, exp_window(rom_row(5), 0)); else passes++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus_a.row_valid !== 1'b1 || bus_a.row_data !== d5 || bus_a.row_idx !== 5'd5)
                $display("FAIL bp_hold cycle %0d: got valid=%b data=%h idx=%0d expected valid=1 data=%h idx=5",
                         k, bus_a.row_valid, bus_a.row_data, bus_a.row_idx, d5);
            else passes++;
        end
        bus_a.row_ready = 1'b1;
        get_row(1'b0, 20, ok, waits, d, idx, off);
        checks++; if (!ok || waits !== 3) $display("FAIL bp_resume_gap: got ok=%0d gap=%0d expected ok=1 gap=3", ok, waits); else passes++;
        checks++; if (idx !== 5'd6) $display("FAIL bp_resume_idx: got %0d expected 6", idx); else passes++;
    endtask

    task automatic test_random();
        int exp_row, frames, exp_off, guard, fd0;
        bit acc;
        reset_a();
        load_random_rom();
        bus_a.run = 1'b1;
        exp_row = 0; frames = 0; fd0 = fd_a;
        for (int n = 0; n < 9*ROWS; n++) begin
            guard = 0; acc = 1'b0;
            while (!acc && guard < 200) begin
                @(negedge clk);
                guard++;
                bus_a.row_ready = ($urandom_range(0, 3) != 0);
                acc = (bus_a.row_valid === 1'b1) && bus_a.row_ready;
            end
            checks++; if (!acc) $display("FAIL rand_timeout row %0d: got no acceptance, expected one within 200 cycles", n); else passes++;
            exp_off = (frames / DIV_A) % SRC_W;
            checks++; if (bus_a.row_idx !== 5'(exp_row)) $display("FAIL rand_idx: got %0d expected %0d", bus_a.row_idx, exp_row); else passes++;
            checks++; if (bus_a.offset !== 7'(exp_off)) $display("FAIL rand_offset frame %0d: got %0d expected %0d", frames, bus_a.offset, exp_off); else passes++;
            checks++;
            if (bus_a.row_data !== exp_window(rom_row(exp_row), exp_off))
                $display("FAIL rand_data row %0d: got %h expected %h", exp_row, bus_a.row_data, exp_window(rom_row(exp_row), exp_off));
            else passes++;
            exp_row++;
            if (exp_row == ROWS) begin
                exp_row = 0;
                frames++;
            end
        end
        bus_a.row_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fd_a - fd0 !== frames) $display("FAIL rand_frame_count: got %0d expected %0d", fd_a - fd0, frames); else passes++;
        checks++; if (bus_a.offset !== 7'((frames / DIV_A) % SRC_W)) $display("FAIL rand_final_offset: got %0d expected %0d", bus_a.offset, (frames / DIV_A) % SRC_W); else passes++;
    endtask

    task automatic test_run_drop();
        bit ok; int waits; logic [WINDOW-1:0] d; logic [4:0] idx; logic [6:0] off;
        int fd0;
        load_spec_rom();
        reset_a();
        bus_a.row_ready = 1'b1;
        bus_a.run = 1'b1;
        fd0 = fd_a;
        for (int n = 0; n < 5*ROWS; n++) begin
            get_row(1'b0, 20, ok, waits, d, idx, off);
            checks++; if (!ok || idx !== 5'(n % ROWS)) $display("FAIL drop_row %0d: got ok=%0d idx=%0d expected ok=1 idx=%0d", n, ok, idx, n % ROWS); else passes++;
            if (n == 4*ROWS + 7) bus_a.run = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++; if (fd_a - fd0 !== 5) $display("FAIL drop_frame_done: got %0d expected 5", fd_a - fd0); else passes++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus_a.row_valid !== 1'b0 || bus_a.rom_addr !== 5'd0)
                $display("FAIL drop_idle cycle %0d: got valid=%b rom_addr=%0d expected valid=0 rom_addr=0", k, bus_a.row_valid, bus_a.rom_addr);
            else passes++;
        end
        checks++; if (bus_a.offset !== 7'((5 / DIV_A) % SRC_W)) $display("FAIL drop_offset_kept: got %0d expected %0d", bus_a.offset, (5 / DIV_A) % SRC_W); else passes++;
        bus_a.run = 1'b1;
        get_row(1'b0, 20, ok, waits, d, idx, off);
        checks++; if (!ok || waits !== 3) $display("FAIL drop_restart_latency: got ok=%0d cycles=%0d expected ok=1 cycles=3", ok, waits); else passes++;
        checks++; if (idx !== 5'd0) $display("FAIL drop_restart_idx: got %0d expected 0", idx); else passes++;
        checks++; if (off !== 7'd1) $display("FAIL drop_restart_offset: got %0d expected 1", off); else passes++;
        checks++; if (d !== exp_window(rom_row(0), 1)) $display("FAIL drop_restart_data: got %h expected %h", d, exp_window(rom_row(0), 1)); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok; int waits; logic [WINDOW-1:0] d; logic [4:0] idx; logic [6:0] off;
        int fd0;
        for (int r = 1; r <= 9; r++) begin
            get_row(1'b0, 20, ok, waits, d, idx, off);
            checks++; if (!ok || idx !== 5'(r)) $display("FAIL rstmid_lead: got ok=%0d idx=%0d expected ok=1 idx=%0d", ok, idx, r); else passes++;
        end
        rst_a = 1'b1;
        fd0 = fd_a;
        @(negedge clk);
        checks++; if (bus_a.row_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", bus_a.row_valid); else passes++;
        checks++; if (bus_a.row_data !== '0) $display("FAIL rstmid_data: got %h expected 0", bus_a.row_data); else passes++;
        checks++; if (bus_a.row_idx !== 5'd0) $display("FAIL rstmid_idx: got %0d expected 0", bus_a.row_idx); else passes++;
        checks++; if (bus_a.frame_done !== 1'b0) $display("FAIL rstmid_frame_done: got %b expected 0", bus_a.frame_done); else passes++;
        checks++; if (bus_a.rom_addr !== 5'd0) $display("FAIL rstmid_rom_addr: got %0d expected 0", bus_a.rom_addr); else passes++;
        checks++; if (bus_a.offset !== 7'd0) $display("FAIL rstmid_offset: got %0d expected 0", bus_a.offset); else passes++;
        rst_a = 1'b0;
        get_row(1'b0, 20, ok, waits, d, idx, off);
        checks++; if (!ok || waits !== 3) $display("FAIL rstmid_restart_latency: got ok=%0d cycles=%0d expected ok=1 cycles=3", ok, waits); else passes++;
        checks++; if (idx !== 5'd0 || off !== 7'd0) $display("FAIL rstmid_restart: got idx=%0d offset=%0d expected idx=0 offset=0", idx, off); else passes++;
        checks++; if (d !== exp_window(rom_row(0), 0)) $display("FAIL rstmid_restart_data: got %h expected %h", d, exp_window(rom_row(0), 0)); else passes++;
        checks++; if (fd_a !== fd0) $display("FAIL rstmid_no_frame_done: got %0d pulses expected 0", fd_a - fd0); else passes++;
    endtask

    task automatic test_wrap();
        bit ok; int waits; logic [WINDOW-1:0] d; logic [4:0] idx; logic [6:0] off;
        int k, eo, fd0;
        load_spec_rom();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        bus_b.row_ready = 1'b1;
        bus_b.run = 1'b1;
        fd0 = fd_b;
        for (int n = 0; n <= SRC_W*ROWS; n++) begin
            get_row(1'b1, 20, ok, waits, d, idx, off);
            checks++; if (!ok || idx !== 5'(n % ROWS)) $display("FAIL wrap_row %0d: got ok=%0d idx=%0d expected ok=1 idx=%0d", n, ok, idx, n % ROWS); else passes++;
            if (n % ROWS == 0) begin
                k  = n / ROWS;
                eo = k % SRC_W;
                checks++; if (off !== 7'(eo)) $display("FAIL wrap_offset frame %0d: got %0d expected %0d", k, off, eo); else passes++;
                checks++; if (d !== exp_window(rom_row(0), eo)) $display("FAIL wrap_data frame %0d: got %h expected %h", k, d, exp_window(rom_row(0), eo)); else passes++;
                if (eo == SRC_W-1) begin
                    checks++; if (d[WINDOW-2] !== 1'b1 || d[WINDOW-1] !== 1'b0) $display("FAIL wrap_at_69: got bits[31:30]=%b%b expected 01", d[WINDOW-1], d[WINDOW-2]); else passes++;
                end
                if (k == SRC_W) begin
                    checks++; if (d[WINDOW-1] !== 1'b1) $display("FAIL wrap_back_to_0: got bit31=%b expected 1", d[WINDOW-1]); else passes++;
                end
            end
        end
        checks++; if (fd_b - fd0 !== SRC_W) $display("FAIL wrap_frame_count: got %0d expected %0d", fd_b - fd0, SRC_W); else passes++;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.run = 1'b0; bus_a.row_ready = 1'b0;
        bus_b.run = 1'b0; bus_b.row_ready = 1'b0;
        load_spec_rom();
        test_reset();
        test_frame();
        test_backpressure();
        test_random();
        test_run_drop();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion by 1 ms, expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
